mult_job_launcher: RTL and testbench
====================================

Name: mult_job_launcher

Overview:
- Initiator side of the start/Done handshake used by app_mult: it launches multiplier runs and waits for each to finish.
- It issues a multi-cycle start pulse, waits for the Done rising edge, and measures per-job latency.
- It repeats this for a programmed number of jobs and guards every job with a timeout watchdog.
- It replaces hand-timed start stimulus: testbenches and the top level use it to drive app_mult deterministically.

Parameters:
- START_W, 2, width in cycles of each mult_start pulse (>=1).
- GAP_CYC, 1, idle cycles between Done detection and the next start pulse (>=0).
- TIMEOUT_CYC, 1024, latency count at which a job is declared timed out.
- CNT_W, 16, width of the latency counters and latency outputs.
- JOB_W, 8, width of the job-count input and completed-job counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  one-cycle request to begin a batch; sampled only in IDLE.
- num_jobs  in  JOB_W  number of jobs in the batch; captured on the cycle go is accepted.
- mult_start  out  1  start to app_mult; high for exactly START_W cycles per job.
- mult_done  in  1  Done from app_mult; only its rising edge is used.
- busy  out  1  high from the cycle after go is accepted until the batch ends.
- all_done  out  1  one-cycle pulse when the batch ends, whether by success or timeout.
- timeout  out  1  sticky error flag; cleared by rst or by the next accepted go.
- jobs_completed  out  JOB_W  number of jobs finished in the current batch.
- last_latency  out  CNT_W  latency of the most recent completed job.
- max_latency  out  CNT_W  largest latency seen in the current batch.

Behaviour:
- Reset: on any rst-high edge, every output goes to 0 and the FSM goes to IDLE, including mid-batch. mult_start is low after that edge.
- Rising-edge detect: register done_q <= mult_done every cycle. done_rise = mult_done & ~done_q. done_q resets to 0, so a mult_done held high through reset counts as a rising edge on the first cycle after reset, but it is ignored unless the FSM is in PULSE or WAIT.
- A Done held high across jobs produces no new edge. The next job then waits until timeout; this is by design.
- IDLE:
  - go=1 and num_jobs>0: capture num_jobs; clear timeout, jobs_completed and max_latency; go to PULSE.
  - go=1 and num_jobs=0: all_done pulses on the next cycle; no start is issued; busy stays 0.
- PULSE:
  - mult_start=1 and busy=1. lat_cnt is 0 in the first PULSE cycle and increments each cycle in PULSE and WAIT.
  - After START_W cycles, go to WAIT.
  - A done_rise during PULSE sets done_seen. The pulse still completes its full width; WAIT then completes immediately on its first cycle.
- WAIT:
  - mult_start=0.
  - On done_rise or done_seen: last_latency <= lat_cnt; max_latency <= max(max_latency, lat_cnt); jobs_completed++.
  - If the batch is complete, go to FIN; otherwise go to GAP, or straight to PULSE when GAP_CYC=0.
  - If lat_cnt reaches TIMEOUT_CYC-1 with no edge: set timeout; jobs_completed is not incremented; go to FIN.
  - If done_rise and the timeout condition occur in the same cycle, done wins.
- GAP: hold for GAP_CYC cycles with mult_start=0, then go to PULSE.
- FIN: all_done=1 for one cycle, busy=0, go to IDLE. The result outputs hold their values until the next go or rst.
- go while busy is ignored. lat_cnt saturates at all-ones and never wraps.

Test Plan:
- Reset hold:
  - Stimulus: rst=1 for 2 cycles with mult_done=1.
  - Required: all outputs 0, mult_start never high.
  - Stimulus: release rst with go=0.
  - Required: outputs stay 0.
- Single job, defaults:
  - Stimulus: go with num_jobs=1; model raises mult_done 5 cycles after the first start cycle.
  - Required: mult_start high exactly 2 cycles; last_latency=5, max_latency=5, jobs_completed=1; one all_done pulse; timeout=0.
- Batch:
  - Stimulus: num_jobs=3; model latencies 4, 9, 6; model drops Done after 1 cycle.
  - Required: 3 start pulses, each separated by GAP_CYC=1 idle cycle after done detection; jobs_completed=3, last_latency=6, max_latency=9.
- Timeout:
  - Stimulus: num_jobs=2; model never asserts Done.
  - Required: after 1024 counted cycles, timeout=1 and all_done pulses; jobs_completed=0; no second start.
  - Stimulus: next go.
  - Required: timeout clears.
- Early done and zero jobs:
  - Stimulus: model raises Done in the 2nd PULSE cycle.
  - Required: start still 2 cycles wide; last_latency=2.
  - Stimulus: go with num_jobs=0.
  - Required: all_done one cycle later; mult_start stays 0.
- Reset mid-batch:
  - Stimulus: assert rst during WAIT of job 2 of 3.
  - Required: all outputs 0 on the next edge; a new go after release starts a fresh batch with jobs_completed counting from 0.

Source files
------------

// File: rtl/mult_job_launcher.sv
// Initiator side of the mult start/Done handshake: launches a batch of multiplier
// jobs, measures each job's latency and guards every job with a timeout watchdog.
//
// state | meaning
// IDLE  | waiting for go; result outputs hold their last values
// PULSE | driving mult_start for START_W cycles
// WAIT  | waiting for the Done rising edge or the watchdog
// GAP   | idle spacing before the next start pulse
// FIN   | one-cycle all_done, batch over
module mult_job_launcher #(
   parameter int START_W     = 2,
   parameter int GAP_CYC     = 1,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16,
   parameter int JOB_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             go_i,
   input  logic [JOB_W-1:0] num_jobs_i,
   output logic             mult_start_o,
   input  logic             mult_done_i,
   output logic             busy_o,
   output logic             all_done_o,
   output logic             timeout_o,
   output logic [JOB_W-1:0] jobs_completed_o,
   output logic [CNT_W-1:0] last_latency_o,
   output logic [CNT_W-1:0] max_latency_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT,
      S_GAP,
      S_FIN
   } state_t;

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_W - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] LAT_MAX    = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic               done_q;
   logic               done_seen_q, done_seen_d;
   logic [CNT_W-1:0]   lat_q, lat_d;
   logic [CNT_W-1:0]   gap_q, gap_d;
   logic [JOB_W-1:0]   njobs_q, njobs_d;
   logic               timeout_q, timeout_d;
   logic [JOB_W-1:0]   jobs_q, jobs_d;
   logic [CNT_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   max_q, max_d;

   logic               done_rise;
   logic [CNT_W-1:0]   lat_inc;
   logic [JOB_W-1:0]   jobs_inc;

   assign done_rise = mult_done_i & ~done_q;
   assign lat_inc   = (lat_q == LAT_MAX) ? lat_q : lat_q + 1'b1;
   assign jobs_inc  = jobs_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         done_q      <= 1'b0;
         done_seen_q <= 1'b0;
         lat_q       <= '0;
         gap_q       <= '0;
         njobs_q     <= '0;
         timeout_q   <= 1'b0;
         jobs_q      <= '0;
         last_q      <= '0;
         max_q       <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= mult_done_i;
         done_seen_q <= done_seen_d;
         lat_q       <= lat_d;
         gap_q       <= gap_d;
         njobs_q     <= njobs_d;
         timeout_q   <= timeout_d;
         jobs_q      <= jobs_d;
         last_q      <= last_d;
         max_q       <= max_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      done_seen_d = done_seen_q;
      lat_d       = lat_q;
      gap_d       = gap_q;
      njobs_d     = njobs_q;
      timeout_d   = timeout_q;
      jobs_d      = jobs_q;
      last_d      = last_q;
      max_d       = max_q;

      case (state_q)
         S_IDLE: begin
            if (go_i) begin
               if (num_jobs_i != '0) begin
                  njobs_d     = num_jobs_i;
                  timeout_d   = 1'b0;
                  jobs_d      = '0;
                  max_d       = '0;
                  lat_d       = '0;
                  done_seen_d = 1'b0;
                  state_d     = S_PULSE;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_PULSE: begin
            lat_d = lat_inc;
            // An early Done is remembered; the pulse still runs its full width.
            if (done_rise) done_seen_d = 1'b1;
            if (lat_q == START_LAST) state_d = S_WAIT;
         end
         S_WAIT: begin
            lat_d = lat_inc;
            if (done_rise || done_seen_q) begin
               last_d      = lat_q;
               if (lat_q > max_q) max_d = lat_q;
               jobs_d      = jobs_inc;
               done_seen_d = 1'b0;
               if (jobs_inc == njobs_q) begin
                  state_d = S_FIN;
               end else if (GAP_CYC == 0) begin
                  lat_d   = '0;
                  state_d = S_PULSE;
               end else begin
                  gap_d   = GAP_LAST;
                  state_d = S_GAP;
               end
            end else if (lat_q >= TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_FIN;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               lat_d       = '0;
               done_seen_d = 1'b0;
               state_d     = S_PULSE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mult_start_o     = (state_q == S_PULSE);
   assign busy_o           = (state_q == S_PULSE) || (state_q == S_WAIT) || (state_q == S_GAP);
   assign all_done_o       = (state_q == S_FIN);
   assign timeout_o        = timeout_q;
   assign jobs_completed_o = jobs_q;
   assign last_latency_o   = last_q;
   assign max_latency_o    = max_q;

endmodule

// File: tb/tb_mult_job_launcher.sv
// Directed bench for mult_job_launcher with a simple Done-responder model
// whose per-job latency is given in cycles after the first start cycle.
module tb_mult_job_launcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       go;
   logic [7:0] num_jobs;
   logic       mult_start;
   logic       mult_done;
   logic       busy;
   logic       all_done;
   logic       timeout;
   logic [7:0] jobs_completed;
   logic [15:0] last_latency;
   logic [15:0] max_latency;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int n_starts, n_alldone, go_cyc, alldone_cyc, first_start_cyc;
   int busy_first, timeout_first, pre_jobs, post_rst_bus;
   int widths[4];
   int gaps[4];
   bit finished, aborted;

   mult_job_launcher dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .go_i             (go),
      .num_jobs_i       (num_jobs),
      .mult_start_o     (mult_start),
      .mult_done_i      (mult_done),
      .busy_o           (busy),
      .all_done_o       (all_done),
      .timeout_o        (timeout),
      .jobs_completed_o (jobs_completed),
      .last_latency_o   (last_latency),
      .max_latency_o    (max_latency)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Launch a batch and act as the multiplier; records what it saw.
   task automatic run_batch(input int nj, input int l0, input int l1, input int l2,
                            input int budget, input int rst_job, input int rst_t);
      int lat[3];
      int job, t, prev_start, cur_w, done_cyc;
      lat = '{l0, l1, l2};
      job = -1; t = 0; prev_start = 0; cur_w = 0; done_cyc = 0;
      n_starts = 0; n_alldone = 0; alldone_cyc = 0; first_start_cyc = 0;
      finished = 0; aborted = 0; pre_jobs = 0; post_rst_bus = -1;
      for (int i = 0; i < 4; i++) begin
         widths[i] = 0;
         gaps[i]   = -1;
      end
      @(negedge clk);
      go = 1'b1; num_jobs = 8'(nj); go_cyc = cyc;
      @(negedge clk);
      go = 1'b0;
      busy_first = int'(busy); timeout_first = int'(timeout);
      for (int k = 0; k < budget; k++) begin
         if (mult_start && !prev_start) begin
            job++; t = 0; cur_w = 0;
            if (n_starts == 0) first_start_cyc = cyc;
            else if (n_starts < 4) gaps[n_starts] = cyc - done_cyc - 1;
            n_starts++;
         end else if (job >= 0) begin
            t++;
         end
         if (mult_start) begin
            cur_w++;
            if (job >= 0 && job < 4) widths[job] = cur_w;
         end
         prev_start = int'(mult_start);
         if (all_done) begin
            n_alldone++; alldone_cyc = cyc; finished = 1;
         end
         if (job >= 0 && job < 3) begin
            if (t == lat[job]) begin
               mult_done = 1'b1; done_cyc = cyc;
            end else if (t == lat[job] + 1) begin
               mult_done = 1'b0;
            end
         end
         if (job == rst_job && t == rst_t) begin
            pre_jobs = int'(jobs_completed);
            rst = 1'b1;
            @(negedge clk);
            post_rst_bus = int'({mult_start, busy, all_done, timeout,
                                 jobs_completed, last_latency, max_latency});
            rst = 1'b0; mult_done = 1'b0; aborted = 1;
            break;
         end
         if (finished) break;
         @(negedge clk);
      end
      mult_done = 1'b0;
      if (finished) begin
         @(negedge clk);
         if (all_done) n_alldone++;
         if (mult_start) n_starts++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 1'b0; num_jobs = 8'd0; mult_done = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({mult_start, busy, all_done, timeout, jobs_completed, last_latency, max_latency} !== 44'd0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: outputs=%h required 0", i,
                     {mult_start, busy, all_done, timeout, jobs_completed, last_latency, max_latency});
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({mult_start, busy, all_done, timeout, jobs_completed, last_latency, max_latency} !== 44'd0) begin
            errors++;
            $display("FAIL reset_release cycle %0d: outputs=%h required 0", i,
                     {mult_start, busy, all_done, timeout, jobs_completed, last_latency, max_latency});
         end
      end
      mult_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_job();
      run_batch(1, 5, -1, -1, 100, -5, 0);
      checks++; if (!finished) begin errors++; $display("FAIL single_budget: all_done never seen within 100 cycles"); end
      checks++; if (busy_first !== 1) begin errors++; $display("FAIL single_busy: got %0d required 1", busy_first); end
      checks++; if (first_start_cyc - go_cyc !== 1) begin errors++; $display("FAIL single_start_lag: got %0d required 1", first_start_cyc - go_cyc); end
      checks++; if (n_starts !== 1) begin errors++; $display("FAIL single_starts: got %0d required 1", n_starts); end
      checks++; if (widths[0] !== 2) begin errors++; $display("FAIL single_width: got %0d required 2", widths[0]); end
      checks++; if (last_latency !== 16'd5) begin errors++; $display("FAIL single_last: got %0d required 5", last_latency); end
      checks++; if (max_latency !== 16'd5) begin errors++; $display("FAIL single_max: got %0d required 5", max_latency); end
      checks++; if (jobs_completed !== 8'd1) begin errors++; $display("FAIL single_jobs: got %0d required 1", jobs_completed); end
      checks++; if (n_alldone !== 1) begin errors++; $display("FAIL single_alldone_count: got %0d required 1", n_alldone); end
      checks++; if (alldone_cyc - first_start_cyc !== 6) begin errors++; $display("FAIL single_alldone_time: got %0d required 6", alldone_cyc - first_start_cyc); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %0d required 0", timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %0d required 0", busy); end
   endtask

   task automatic test_batch();
      run_batch(3, 4, 9, 6, 200, -5, 0);
      checks++; if (!finished) begin errors++; $display("FAIL batch_budget: all_done never seen within 200 cycles"); end
      checks++; if (n_starts !== 3) begin errors++; $display("FAIL batch_starts: got %0d required 3", n_starts); end
      for (int j = 0; j < 3; j++) begin
         checks++; if (widths[j] !== 2) begin errors++; $display("FAIL batch_width job %0d: got %0d required 2", j, widths[j]); end
      end
      for (int j = 1; j < 3; j++) begin
         checks++; if (gaps[j] !== 1) begin errors++; $display("FAIL batch_gap job %0d: got %0d required 1", j, gaps[j]); end
      end
      checks++; if (jobs_completed !== 8'd3) begin errors++; $display("FAIL batch_jobs: got %0d required 3", jobs_completed); end
      checks++; if (last_latency !== 16'd6) begin errors++; $display("FAIL batch_last: got %0d required 6", last_latency); end
      checks++; if (max_latency !== 16'd9) begin errors++; $display("FAIL batch_max: got %0d required 9", max_latency); end
      checks++; if (n_alldone !== 1) begin errors++; $display("FAIL batch_alldone_count: got %0d required 1", n_alldone); end
   endtask

   task automatic test_timeout();
      run_batch(2, -1, -1, -1, 1200, -5, 0);
      checks++; if (!finished) begin errors++; $display("FAIL timeout_budget: all_done never seen within 1200 cycles"); end
      checks++; if (alldone_cyc - first_start_cyc !== 1024) begin errors++; $display("FAIL timeout_time: got %0d required 1024", alldone_cyc - first_start_cyc); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %0d required 1", timeout); end
      checks++; if (jobs_completed !== 8'd0) begin errors++; $display("FAIL timeout_jobs: got %0d required 0", jobs_completed); end
      checks++; if (n_starts !== 1) begin errors++; $display("FAIL timeout_starts: got %0d required 1", n_starts); end
      run_batch(1, 3, -1, -1, 100, -5, 0);
      checks++; if (timeout_first !== 0) begin errors++; $display("FAIL timeout_clear_on_go: got %0d required 0", timeout_first); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_after_rerun: got %0d required 0", timeout); end
      checks++; if (max_latency !== 16'd3) begin errors++; $display("FAIL timeout_rerun_max: got %0d required 3", max_latency); end
   endtask

   task automatic test_early_done_zero_jobs();
      run_batch(1, 1, -1, -1, 100, -5, 0);
      checks++; if (!finished) begin errors++; $display("FAIL early_budget: all_done never seen within 100 cycles"); end
      checks++; if (widths[0] !== 2) begin errors++; $display("FAIL early_width: got %0d required 2", widths[0]); end
      checks++; if (last_latency !== 16'd2) begin errors++; $display("FAIL early_last: got %0d required 2", last_latency); end
      checks++; if (jobs_completed !== 8'd1) begin errors++; $display("FAIL early_jobs: got %0d required 1", jobs_completed); end
      run_batch(0, -1, -1, -1, 20, -5, 0);
      checks++; if (!finished) begin errors++; $display("FAIL zero_budget: all_done never seen within 20 cycles"); end
      checks++; if (alldone_cyc - go_cyc !== 1) begin errors++; $display("FAIL zero_alldone_time: got %0d required 1", alldone_cyc - go_cyc); end
      checks++; if (n_starts !== 0) begin errors++; $display("FAIL zero_starts: got %0d required 0", n_starts); end
      checks++; if (busy_first !== 0) begin errors++; $display("FAIL zero_busy: got %0d required 0", busy_first); end
      checks++; if (n_alldone !== 1) begin errors++; $display("FAIL zero_alldone_count: got %0d required 1", n_alldone); end
   endtask

   task automatic test_reset_mid_batch();
      run_batch(3, 4, 9, 6, 200, 1, 5);
      checks++; if (!aborted) begin errors++; $display("FAIL midrst_reached: reset point never reached"); end
      checks++; if (pre_jobs !== 1) begin errors++; $display("FAIL midrst_pre_jobs: got %0d required 1", pre_jobs); end
      checks++; if (post_rst_bus !== 0) begin errors++; $display("FAIL midrst_outputs: got %h required 0", post_rst_bus); end
      run_batch(1, 5, -1, -1, 100, -5, 0);
      checks++; if (!finished) begin errors++; $display("FAIL midrst_rerun_budget: all_done never seen within 100 cycles"); end
      checks++; if (jobs_completed !== 8'd1) begin errors++; $display("FAIL midrst_rerun_jobs: got %0d required 1", jobs_completed); end
      checks++; if (last_latency !== 16'd5) begin errors++; $display("FAIL midrst_rerun_last: got %0d required 5", last_latency); end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_batch();
      test_timeout();
      test_early_done_zero_jobs();
      test_reset_mid_batch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
